q4_share_sched: RTL and testbench
=================================

// Module: q4_share_sched
// PURPOSE
//  Time-shares one combinational Q4 datapath (six DW-bit operands a..f -> results x,y,z) among NUM_REQ requesters.
//  A round-robin arbiter grants one operand bundle at a time. The block drives the bundle onto the datapath,
//  waits SETTLE cycles, then captures x/y/z. The result is returned tagged with the requester id.
//  Sits between the requester clients and the single Q4 instance; Q4 itself is unchanged.
// PARAMETERS
//  NUM_REQ  4  number of requesters (2..8)
//  DW       8  operand/result width, matches Q4 ports
//  SETTLE   1  cycles the operands are held on dp_* before capture (>=1)
// PORTS
//  clk        in   1               system clock, all logic on rising edge
//  rst        in   1               synchronous, active-high reset
//  req_valid  in   NUM_REQ         requester i has a bundle on req_ops slice i
//  req_ops    in   NUM_REQ*6*DW    slice i = {a,b,c,d,e,f}, a in MSBs
//  req_ready  out  NUM_REQ         one-hot accept pulse for the granted requester
//  dp_a..dp_f out  DW each         operands driven to the Q4 datapath
//  dp_x,dp_y,dp_z in DW each       Q4 results
//  rsp_valid  out  1               result available
//  rsp_ready  in   1               consumer accepts result
//  rsp_id     out  $clog2(NUM_REQ) requester index of this result
//  rsp_x,rsp_y,rsp_z out DW each   captured results
//  busy       out  1               high in any state other than IDLE
// BEHAVIOUR
//  Reset values: req_ready=0, dp_*=0, rsp_valid=0, rsp_id=0, rsp_x/y/z=0, busy=0.
//  Reset values: rr pointer=0, FSM=IDLE.
//  FSM IDLE -> HOLD -> RESP -> IDLE.
//  IDLE: if any req_valid, grant the first valid index at or after the rr pointer.
//    Assert req_ready[g] combinationally this cycle (handshake T). Register slice g into dp_* and g into rsp_id.
//    Set the rr pointer to (g+1) mod NUM_REQ. Go to HOLD with settle counter=SETTLE-1.
//  IDLE with no req_valid: stay; dp_* keep their last values.
//  HOLD: dp_* stable. If counter==0, register dp_x/y/z into rsp_x/y/z, set rsp_valid, go to RESP.
//    Otherwise decrement the counter.
//  Result: rsp_valid rises at T+1+SETTLE.
//  RESP: hold rsp_* stable while rsp_valid && !rsp_ready.
//    On rsp_valid && rsp_ready: clear rsp_valid, go to IDLE.
//    A new grant can occur the cycle after the response handshake (no overlap).
//  req_ready is never asserted outside IDLE; at most one bit is set.
//  A requester that drops req_valid before grant is skipped without penalty.
//  A requester that keeps req_valid high loses to other valid requesters until the pointer returns to it.
//  Reset mid-operation (HOLD or RESP) discards the in-flight bundle. No response is produced.
//  A requester whose bundle was accepted must not wait for it after rst.
//  Widths: dp_*/rsp_* are exactly DW bits. No arithmetic is performed here; values pass through unmodified.
//  Pointer wrap-around: NUM_REQ-1 -> 0.
// STRUCTURE
//  Package q4_sched_pkg: FSM state enum (IDLE, HOLD, RESP), operand field offsets within a slice (A_OFS..F_OFS).
//  Sub-module rr_arbiter #(NUM_REQ):
//    inputs req[NUM_REQ], ptr, en
//    outputs gnt one-hot, gnt_idx, any
//    purely combinational; the pointer register lives in q4_share_sched.
//  Top holds the FSM, settle counter, operand/result registers and pointer.
// TESTING  (bench Q4 stub: x=a+b, y=c^d, z=e-f, mod 256)
//  1 Single request, DW=8, SETTLE=1:
//    req_valid=0001, slice0={12,2,8'hA9,8,8'hB4,2}
//    -> req_ready=0001 at T; rsp_valid at T+2; rsp_id=0, x=14, y=8'hA1, z=8'hB2.
//  2 req_valid=1111 held for 8 responses, rsp_ready=1
//    -> grant order 0,1,2,3,0,1,2,3; every req_ready pulse is exactly one-hot.
//  3 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid
//    -> rsp_x/y/z/id stable, no req_ready pulses, busy=1; accept, then next grant occurs 1 cycle later.
//  4 SETTLE=3, single request -> rsp_valid exactly at T+4.
//    Changing dp_x stub value during HOLD before the last cycle does not affect the captured value.
//  5 rst pulsed in HOLD -> next cycle all outputs at reset values, pointer=0.
//    Next req_valid=1010 grants index 1.
//  6 Pointer wrap: grant index 3 with req_valid=1001 -> next grant is index 0.

Source files
------------

// File: rtl/q4_sched_pkg.sv
// Shared definitions for the Q4 time-sharing scheduler.
//   state_t      : scheduler FSM states
//   NUM_OPS      : operands per request bundle (a..f)
//   A_OFS..F_OFS : field index of each operand inside a bundle slice.
//                  Field k occupies bits [k*DW +: DW], so a sits in the MSBs.
package q4_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int NUM_OPS = 6;
  localparam int A_OFS   = 5;
  localparam int B_OFS   = 4;
  localparam int C_OFS   = 3;
  localparam int D_OFS   = 2;
  localparam int E_OFS   = 1;
  localparam int F_OFS   = 0;

endpackage

// File: rtl/q4_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req     : request vector
//   ptr     : index with the highest priority this cycle
//   en      : when low, nothing is granted
//   gnt     : one-hot grant
//   gnt_idx : index of the granted request
//   any     : a grant was issued
// The pointer register is owned by the instantiating block.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               any
);

  always_comb begin : pick
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    // Scan from the farthest offset back toward ptr so the nearest valid
    // request at or after ptr is the last one written and therefore wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (en && req[idx]) begin
        any     = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
    if (any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/q4_share_sched.sv
// Time-shares a single combinational Q4 datapath among NUM_REQ requesters.
// A round-robin grant loads one operand bundle onto dp_a..dp_f, the bundle
// is held for SETTLE cycles, then dp_x/y/z are captured and returned with the
// requester index.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ops   : per-requester bundle {a,b,c,d,e,f}, a in MSBs
//   req_ready           : one-hot accept pulse (combinational, IDLE only)
//   dp_a..dp_f          : operands to Q4
//   dp_x, dp_y, dp_z    : Q4 results
//   rsp_valid/rsp_ready : result handshake
//   rsp_id, rsp_x/y/z   : requester index and captured results
//   busy                : FSM not in IDLE
//
// state | meaning
// IDLE  | waiting for a request; grant happens here
// HOLD  | operands held on dp_*, settle counter running down
// RESP  | result presented until the consumer accepts it
module q4_share_sched
  import q4_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DW      = 8,
  parameter int SETTLE  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*NUM_OPS*DW-1:0] req_ops,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DW-1:0]                 dp_a,
  output logic [DW-1:0]                 dp_b,
  output logic [DW-1:0]                 dp_c,
  output logic [DW-1:0]                 dp_d,
  output logic [DW-1:0]                 dp_e,
  output logic [DW-1:0]                 dp_f,
  input  logic [DW-1:0]                 dp_x,
  input  logic [DW-1:0]                 dp_y,
  input  logic [DW-1:0]                 dp_z,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_id,
  output logic [DW-1:0]                 rsp_x,
  output logic [DW-1:0]                 rsp_y,
  output logic [DW-1:0]                 rsp_z,
  output logic                          busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = NUM_OPS * DW;
  // A one-cycle settle needs no real counter but keep one bit so the
  // terminal-count compare stays uniform.
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t               state;
  logic [IW-1:0]        ptr;
  logic [CW-1:0]        cnt;
  logic [NUM_REQ-1:0]   gnt;
  logic [IW-1:0]        gnt_idx;
  logic                 any;
  logic [SW-1:0]        slice;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (state == IDLE && !rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  assign req_ready = gnt;
  assign busy      = (state != IDLE);
  assign slice     = req_ops[int'(gnt_idx) * SW +: SW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      dp_a      <= '0;
      dp_b      <= '0;
      dp_c      <= '0;
      dp_d      <= '0;
      dp_e      <= '0;
      dp_f      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_x     <= '0;
      rsp_y     <= '0;
      rsp_z     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            dp_a   <= slice[A_OFS*DW +: DW];
            dp_b   <= slice[B_OFS*DW +: DW];
            dp_c   <= slice[C_OFS*DW +: DW];
            dp_d   <= slice[D_OFS*DW +: DW];
            dp_e   <= slice[E_OFS*DW +: DW];
            dp_f   <= slice[F_OFS*DW +: DW];
            rsp_id <= gnt_idx;
            ptr    <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            cnt    <= CW'(SETTLE - 1);
            state  <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            rsp_x     <= dp_x;
            rsp_y     <= dp_y;
            rsp_z     <= dp_z;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_q4_share_sched.sv
// Bench for q4_share_sched: a SETTLE=1 instance exercised with directed and
// randomized transactions against a transaction-level model, and a SETTLE=3
// instance for capture timing.
module tb_q4_share_sched;

  localparam int N      = 4;
  localparam int DW     = 8;
  localparam int SW     = 6 * DW;
  localparam int SETTLE = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int m_ptr       = 0;

  // SETTLE=1 instance
  logic [N-1:0]    req_valid, req_ready;
  logic [N*SW-1:0] req_ops;
  logic [DW-1:0]   dp_a, dp_b, dp_c, dp_d, dp_e, dp_f, dp_x, dp_y, dp_z;
  logic            rsp_valid, rsp_ready, busy;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_x, rsp_y, rsp_z;

  assign dp_x = dp_a + dp_b;
  assign dp_y = dp_c ^ dp_d;
  assign dp_z = dp_e - dp_f;

  q4_share_sched #(.NUM_REQ(N), .DW(DW), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ops(req_ops),
    .req_ready(req_ready), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c),
    .dp_d(dp_d), .dp_e(dp_e), .dp_f(dp_f), .dp_x(dp_x), .dp_y(dp_y),
    .dp_z(dp_z), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
    .busy(busy)
  );

  // SETTLE=3 instance; pert disturbs the stub x result during early HOLD
  logic [N-1:0]    rv_s, rr_s;
  logic [N*SW-1:0] ops_s;
  logic [DW-1:0]   a_s, b_s, c_s, d_s, e_s, f_s, x_s, y_s, z_s, pert;
  logic            rspv_s, rspr_s, busy_s;
  logic [1:0]      id_s;
  logic [DW-1:0]   rx_s, ry_s, rz_s;

  assign x_s = (a_s + b_s) ^ pert;
  assign y_s = c_s ^ d_s;
  assign z_s = e_s - f_s;

  q4_share_sched #(.NUM_REQ(N), .DW(DW), .SETTLE(3)) dut_s3 (
    .clk(clk), .rst(rst), .req_valid(rv_s), .req_ops(ops_s),
    .req_ready(rr_s), .dp_a(a_s), .dp_b(b_s), .dp_c(c_s),
    .dp_d(d_s), .dp_e(e_s), .dp_f(f_s), .dp_x(x_s), .dp_y(y_s),
    .dp_z(z_s), .rsp_valid(rspv_s), .rsp_ready(rspr_s),
    .rsp_id(id_s), .rsp_x(rx_s), .rsp_y(ry_s), .rsp_z(rz_s),
    .busy(busy_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: first valid index at or after the pointer.
  function automatic int pick(input logic [N-1:0] mask);
    for (int k = 0; k < N; k++)
      if (mask[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  // Model of the Q4 stub: {x,y,z} from {a,b,c,d,e,f}
  function automatic logic [23:0] q4(input logic [SW-1:0] s);
    logic [7:0] a, b, c, d, e, f, x, y, z;
    {a, b, c, d, e, f} = s;
    x = a + b;
    y = c ^ d;
    z = e - f;
    return {x, y, z};
  endfunction

  task automatic rand_ops();
    for (int i = 0; i < N; i++)
      req_ops[i*SW +: SW] = {$urandom, $urandom};
  endtask

  task automatic chk_reset();
    chk("rst_ready", req_ready, 0);
    chk("rst_dp", {dp_a, dp_b, dp_c, dp_d, dp_e, dp_f}, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_xyz", {rsp_x, rsp_y, rsp_z}, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic idle_cycle();
    req_valid = '0;
    #1;
    chk("idle_ready", req_ready, 0);
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;
  endtask

  // One full transaction; entered and left one tick after a rising edge
  // with the DUT idle. bp = cycles of rsp_ready=0 after rsp_valid rises.
  task automatic xact(input logic [N-1:0] mask, input int bp);
    int g;
    logic [SW-1:0] s;
    logic [23:0] e;
    req_valid = mask;
    rsp_ready = 1'b0;
    g = pick(mask);
    s = req_ops[g*SW +: SW];
    e = q4(s);
    #1;
    chk("grant", req_ready, 64'(1) << g);
    chk("busy_idle", busy, 0);
    for (int c = 0; c < SETTLE; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        chk("dp_ops", {dp_a, dp_b, dp_c, dp_d, dp_e, dp_f}, s);
        rand_ops();
      end
      chk("hold_ready", req_ready, 0);
      chk("hold_valid", rsp_valid, 0);
      chk("hold_busy", busy, 1);
    end
    @(posedge clk); #1;
    for (int c = 0; c <= bp; c++) begin
      if (c == bp) rsp_ready = 1'b1;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, g);
      chk("rsp_xyz", {rsp_x, rsp_y, rsp_z}, e);
      chk("resp_ready", req_ready, 0);
      chk("resp_busy", busy, 1);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    chk("valid_clr", rsp_valid, 0);
    chk("busy_clr", busy, 0);
    m_ptr = (g + 1) % N;
  endtask

  initial begin
    req_valid = '0; req_ops = '0; rsp_ready = 1'b0;
    rv_s = '0; ops_s = '0; rspr_s = 1'b0; pert = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_reset();
    m_ptr = 0;

    // single request with known operands
    req_ops[0 +: SW] = {8'd12, 8'd2, 8'hA9, 8'd8, 8'hB4, 8'd2};
    xact(4'b0001, 0);
    chk("t1_const", q4({8'd12, 8'd2, 8'hA9, 8'd8, 8'hB4, 8'd2}) ^ {rsp_x, rsp_y, rsp_z}, 0);

    // all requesting: strict rotation
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; m_ptr = 0;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      xact(4'b1111, 0);
    end

    // backpressure, then immediate next grant
    rand_ops();
    xact(4'b0110, 5);
    xact(4'b0110, 0);

    // reset in HOLD discards the bundle and clears the pointer
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0; m_ptr = 0;
    rand_ops();
    xact(4'b0010, 0);
    req_valid = 4'b0100;
    #1;
    chk("pre_rst_grant", req_ready, 4'b0100);
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset();
    m_ptr = 0;
    @(posedge clk); #1;
    chk("post_rst_valid", rsp_valid, 0);
    xact(4'b1010, 0);

    // pointer wrap 3 -> 0
    xact(4'b0100, 0);
    xact(4'b1001, 0);
    xact(4'b1001, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      rand_ops();
      xact(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

    // SETTLE=3: capture uses only the final HOLD cycle
    begin
      logic [23:0] e;
      for (int i = 0; i < N; i++) ops_s[i*SW +: SW] = {$urandom, $urandom};
      e = q4(ops_s[0 +: SW]);
      rv_s = 4'b0001;
      #1;
      chk("s3_grant", rr_s, 4'b0001);
      for (int c = 1; c <= 3; c++) begin
        @(posedge clk); #1;
        pert = (c < 3) ? 8'h5A : 8'h00;
        chk("s3_hold_valid", rspv_s, 0);
        chk("s3_hold_busy", busy_s, 1);
      end
      @(posedge clk); #1;
      chk("s3_valid", rspv_s, 1);
      chk("s3_id", id_s, 0);
      chk("s3_xyz", {rx_s, ry_s, rz_s}, e);
      rspr_s = 1'b1;
      rv_s = '0;
      @(posedge clk); #1;
      rspr_s = 1'b0;
      chk("s3_clr", rspv_s, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
